// File: rtl/pool_stream_relu.sv
// rtl/pool_stream_relu.sv - captures a pooled FP16 vector and streams it out one element per handshake with optional ReLU
module pool_stream_relu #(
  parameter int DATA_WIDTH = 16,
  parameter int InputH     = 14,
  parameter int InputW     = 14,
  parameter int Depth      = 1,
  parameter int RELU_EN    = 1,
  localparam int N         = InputH * InputW * Depth,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] pool_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [IW-1:0]           out_idx,
  output logic                    out_last,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         k_q, k_d;
  logic                  capture;
  logic [DATA_WIDTH-1:0] buf_q [N];
  logic [DATA_WIDTH-1:0] elem;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Buffer needs no reset: it is only read while streaming, which always follows a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= pool_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (k_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign elem = buf_q[k_q];

  // Sign bit set clears the element, so -0.0 and negative NaNs also map to +0.0.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_idx   = k_q;
        out_last  = (k_q == LAST_IDX);
        if ((RELU_EN != 0) && elem[DATA_WIDTH-1]) begin
          out_data = '0;
        end else begin
          out_data = elem;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/pool_stream_relu.md
# pool_stream_relu

Sequential stage directly downstream of the combinational 2x2 max-pool block. Captures the full pooled feature vector in one cycle, applies an FP16 ReLU per element, and streams elements one per handshake (valid/ready) to the next layer (flatten / fully-connected input). It converts the wide parallel pool output into a serial stream with an element index, last flag and completion pulse.

## Interface
- DATA_WIDTH, 16, element width (IEEE-754 half precision)
- InputH, 14, pooled map height
- InputW, 14, pooled map width
- Depth, 1, channel count
- RELU_EN, 1, 1 = apply ReLU, 0 = pass elements through unchanged
- Derived: N = InputH*InputW*Depth (196 by default); IW = max(1, clog2(N))
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  capture request, sampled only in IDLE
- pool_in  in  N*DATA_WIDTH  pooled vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  high from capture through DONE
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  current element after ReLU
- out_idx  out  IW  index k of current element
- out_last  out  1  high while k == N-1 is presented
- done  out  1  one-cycle pulse after final element accepted

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: start=1 -> register pool_in into internal buffer, k<=0, go STREAM. start=0 -> stay.
- STREAM: out_valid=1, out_data = f(buffer[k]), out_idx=k, out_last=(k==N-1).
  - Handshake (out_valid && out_ready): k<N-1 -> k<=k+1; k==N-1 -> go DONE.
  - No handshake: all outputs held stable (no bubble, no change of data while valid).
- DONE: done=1, out_valid=0, busy=1 for exactly one cycle; next state IDLE.
- ReLU f(x) with RELU_EN=1: sign bit (MSB) = 1 -> 0x0000 (covers negatives, -0.0 0x8000, negative NaN); else x unchanged. RELU_EN=0: f(x)=x.
- start while busy (STREAM or DONE): ignored; buffer not overwritten.
- pool_in changes after capture: no effect on current stream.
- Reset (any state, including mid-stream): state IDLE, k=0, all outputs 0, no done pulse; buffer contents don't-care.
- N==1: single element presented with out_last=1, out_idx=0.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0.
- start sampled at edge E0 (in IDLE) -> out_valid=1, busy=1, element 0 visible after E0 (latency 1 cycle).
- Throughput: 1 element/cycle with out_ready held high; N elements in N cycles.
- Final handshake at edge Ef -> after Ef: out_valid=0, done=1; after Ef+1: done=0, busy=0, IDLE.
- Earliest next start: sampled at edge Ef+2 (first edge in IDLE); start=1 during DONE is dropped.
- Minimum capture-to-done for N elements, ready always high: start edge to done rising = N+1 edges.
- All outputs registered or driven from registered state + buffer mux; no combinational path from out_ready to out_valid.

## Test plan
- Reset then idle: reset=1 for 2 cycles with start=1 -> all outputs 0, no capture; release reset, start=0 -> stays idle, outputs 0.
- Full stream, ready high: pool_in elements alternating 0x4500/0x4200, pulse start -> 196 consecutive cycles out_valid=1, out_idx 0..195, data 0x4500,0x4200,..., out_last only at idx 195, done one cycle after, busy drops next cycle.
- ReLU: elements 0xC200, 0x8000, 0x0000, 0x7C00, 0xFE00 -> outputs 0x0000, 0x0000, 0x0000, 0x7C00, 0x0000; same with RELU_EN=0 -> unchanged.
- Backpressure: out_ready low for 3 cycles while idx=5 -> idx 5 and data held stable, out_valid stays 1; resumes at idx 6 after ready returns; total stream length = 196+3 cycles.
- Start during busy / input change: second start pulse at idx 10 and pool_in changed to all 0x4400 -> stream continues with originally captured data, single done pulse; start during DONE ignored.
- Mid-stream reset: reset at idx 50 -> next cycle outputs 0, no done; fresh start afterwards streams from idx 0 with new data.
